// File: rtl/cube_state_entry_if.sv
// Bundles the button pulses, facelet read port and status outputs of the cube
// state entry block into one interface.
interface cube_state_entry_if;
   logic       next_pulse;
   logic       prev_pulse;
   logic       colour_pulse;
   logic       commit_pulse;
   logic       clear_pulse;
   logic [5:0] rd_addr;
   logic [2:0] rd_colour;
   logic [5:0] cursor;
   logic [2:0] cur_colour;
   logic       locked;
   logic       valid_pulse;
   logic       error_pulse;

   modport master (
      output next_pulse, prev_pulse, colour_pulse, commit_pulse, clear_pulse, rd_addr,
      input  rd_colour, cursor, cur_colour, locked, valid_pulse, error_pulse
   );

   modport slave (
      input  next_pulse, prev_pulse, colour_pulse, commit_pulse, clear_pulse, rd_addr,
      output rd_colour, cursor, cur_colour, locked, valid_pulse, error_pulse
   );
endinterface

// File: rtl/cube_state_entry.sv
// Facelet colour entry for a 3x3 cube: cursor-driven editing, per-colour counts,
// and a one-cycle validity check that locks the pattern when it is plausible.
module cube_state_entry #(
   parameter int NUM_FACELETS = 54,
   parameter int NUM_COLOURS  = 6
) (
   input  logic               clk,
   input  logic               rst,
   cube_state_entry_if.slave  bus
);
   localparam logic [1:0] EDIT   = 2'd0;
   localparam logic [1:0] CHECK  = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;

   localparam logic [5:0] LAST_FACELET = 6'(NUM_FACELETS - 1);
   localparam logic [2:0] LAST_COLOUR  = 3'(NUM_COLOURS - 1);

   logic [2:0] entry_reg [0:NUM_FACELETS-1];
   logic [3:0] count_reg [0:NUM_COLOURS-1];
   logic [5:0] cursor_reg;
   logic [1:0] state_reg;
   logic       valid_pulse_reg;
   logic       error_pulse_reg;

   logic [2:0] centre [0:5];
   logic [2:0] colour_old;
   logic [2:0] colour_new;
   logic       check_pass;

   for (genvar gi = 0; gi < 6; gi++) begin : g_centre
      assign centre[gi] = entry_reg[9*gi + 4];
   end

   assign colour_old = entry_reg[cursor_reg];
   assign colour_new = (colour_old == LAST_COLOUR) ? 3'd0 : colour_old + 3'd1;

   // Counts are 4 bits wide and may wrap, but six counts that each read 9 and
   // sum to 54 can only be exactly 9, so the check remains exact.
   always_comb begin
      check_pass = 1'b1;
      for (int c = 0; c < NUM_COLOURS; c++) begin
         if (count_reg[c] != 4'd9) check_pass = 1'b0;
      end
      for (int a = 0; a < 6; a++) begin
         for (int b = a + 1; b < 6; b++) begin
            if (centre[a] == centre[b]) check_pass = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.clear_pulse) begin
         for (int i = 0; i < NUM_FACELETS; i++) entry_reg[i] <= 3'(i / 9);
         for (int c = 0; c < NUM_COLOURS; c++) count_reg[c] <= 4'd9;
         cursor_reg      <= 6'd0;
         state_reg       <= EDIT;
         valid_pulse_reg <= 1'b0;
         error_pulse_reg <= 1'b0;
      end else begin
         valid_pulse_reg <= 1'b0;
         error_pulse_reg <= 1'b0;
         case (state_reg)
            EDIT: begin
               if (bus.commit_pulse) begin
                  state_reg <= CHECK;
               end else if (bus.colour_pulse) begin
                  entry_reg[cursor_reg] <= colour_new;
                  count_reg[colour_old] <= count_reg[colour_old] - 4'd1;
                  count_reg[colour_new] <= count_reg[colour_new] + 4'd1;
               end else if (bus.next_pulse) begin
                  cursor_reg <= (cursor_reg == LAST_FACELET) ? 6'd0 : cursor_reg + 6'd1;
               end else if (bus.prev_pulse) begin
                  cursor_reg <= (cursor_reg == 6'd0) ? LAST_FACELET : cursor_reg - 6'd1;
               end
            end
            CHECK: begin
               if (check_pass) begin
                  state_reg       <= LOCKED;
                  valid_pulse_reg <= 1'b1;
               end else begin
                  state_reg       <= EDIT;
                  error_pulse_reg <= 1'b1;
               end
            end
            LOCKED: begin
               if (bus.commit_pulse) state_reg <= EDIT;
            end
            default: state_reg <= EDIT;
         endcase
      end
   end

   assign bus.rd_colour   = (bus.rd_addr <= LAST_FACELET) ? entry_reg[bus.rd_addr] : 3'd0;
   assign bus.cursor      = cursor_reg;
   assign bus.cur_colour  = entry_reg[cursor_reg];
   assign bus.locked      = (state_reg == LOCKED);
   assign bus.valid_pulse = valid_pulse_reg;
   assign bus.error_pulse = error_pulse_reg;
endmodule
